load_counter: RTL and testbench
===============================

// Module: load_counter
// PURPOSE
//   Loadable up/down counter with run/pause/stop control and a wrap pulse.
//   Software-style controls (load, direction, start, continue) drive a BIT_WIDTH
//   count, which is used as a general-purpose timer/event counter.
//   pulse flags each terminal-count wrap-around.
// PARAMETERS
//   BIT_WIDTH  16  width of count; load[BIT_WIDTH-1:0] is used, upper load bits ignored
// PORTS
//   clk         in   1          single clock, all state updates on rising edge
//   reset       in   1          asynchronous, active-low reset
//   load        in   32         preload value (low BIT_WIDTH bits used)
//   load_en     in   1          1 = load count from load this cycle
//   upordown    in   1          1 = count up, 0 = count down
//   start       in   1          1 = counter enabled (run/pause), 0 = stop
//   continue_1  in   1          1 = advance, 0 = pause (valid only while start=1)
//   count       out  BIT_WIDTH  current count (registered)
//   pulse       out  1          one-cycle wrap flag (registered)
// BEHAVIOUR
//   Reset (reset=0, async): count=0, pulse=0, state=IDLE. Held while reset=0.
//   FSM states: IDLE (stopped), RUN, PAUSED; evaluated each rising clk edge:
//     any state, start=0            -> IDLE
//     IDLE,   start=1 & continue_1=1 -> RUN
//     IDLE,   start=1 & continue_1=0 -> PAUSED
//     RUN,    start=1 & continue_1=0 -> PAUSED
//     PAUSED, start=1 & continue_1=1 -> RUN
//   Count update priority, per edge:
//     1. load_en=1: count <= load[BIT_WIDTH-1:0] in any state; no step, pulse=0.
//        FSM still transitions normally.
//     2. else state==RUN (current registered state): count steps by 1.
//        upordown=1 -> +1, upordown=0 -> -1, modulo 2^BIT_WIDTH.
//     3. else: count holds. Stop does NOT clear count; PAUSED/IDLE both hold.
//   Starting from IDLE: the first step occurs on the edge after entry to RUN
//     (1-cycle latency from start/continue_1 sampled high to first count change).
//   upordown is sampled every edge; a direction change takes effect on the next step.
//   pulse <= 1 for exactly one cycle on the edge where a step wraps:
//     up: count==2^BIT_WIDTH-1 -> 0.  down: count==0 -> 2^BIT_WIDTH-1.
//     Otherwise pulse <= 0. A load never produces a pulse.
//   Reset mid-run: immediate clear of count/pulse, FSM to IDLE, regardless of inputs.
//   All outputs come directly from flops (no combinational input-to-output paths).
// TESTING
//   1. reset=0 for 10 cycles with random inputs -> count=0, pulse=0 throughout.
//      After reset=1 with start=0: count stays 0.
//   2. load_en=1, load=32'd100, upordown=1, start=0 -> count=100 next edge.
//      count holds at 100 while start=0.
//   3. After test 2: start=1, continue_1=1 for 10 cycles -> count 100,101,...
//      Count reaches 109/110 (1-cycle latency). Then continue_1=0 -> count freezes.
//      Then continue_1=1 -> counting resumes from the frozen value.
//   4. load=16'hFFFE, up, run -> FFFF, 0000, pulse=1 in the 0000 cycle only.
//      Load 0x0001, down -> 0000, FFFF with pulse=1 in the FFFF cycle.
//   5. During RUN, load_en=1 with load=32'h0001_0005 -> count=0x0005, no step that cycle.
//      Stepping continues afterwards.
//   6. During RUN, assert reset=0 asynchronously mid-cycle -> count=0 at once.
//      After release, no counting until start=1 & continue_1=1.

Source files
------------

// File: rtl/load_counter.sv
`default_nettype none
// ============================================================================
//  Module      : load_counter
//  Description : Loadable up/down counter with run/pause/stop control. The
//                control FSM (IDLE / RUN / PAUSED) gates stepping. A one-cycle
//                registered pulse flags every terminal-count wrap-around.
//  Revision    : 1.0  initial release
// ============================================================================
module load_counter #(
    parameter int BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,       // asynchronous, active-low
    input  logic [31:0]          load,
    input  logic                 load_en,
    input  logic                 upordown,
    input  logic                 start,
    input  logic                 continue_1,
    output logic [BIT_WIDTH-1:0] count,
    output logic                 pulse
);

    // Terminal values used for wrap detection in each direction.
    localparam logic [BIT_WIDTH-1:0] C_ALL_ONES = {BIT_WIDTH{1'b1}};
    localparam logic [BIT_WIDTH-1:0] C_ZERO     = {BIT_WIDTH{1'b0}};
    localparam logic [BIT_WIDTH-1:0] C_ONE      = {{(BIT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BIT_WIDTH-1:0] count_next;
    logic                 pulse_next;
    logic                 step;
    logic                 wrap;

    // State register; reset forces IDLE regardless of any other input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start low always stops; otherwise continue_1 picks
    // between running and pausing from any state.
    always_comb begin
        state_next = state;
        if (!start) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = continue_1 ? RUN : PAUSED;
                RUN:     state_next = continue_1 ? RUN : PAUSED;
                PAUSED:  state_next = continue_1 ? RUN : PAUSED;
                default: state_next = IDLE;
            endcase
        end
    end

    // Count datapath: a load beats a step, and stepping uses the registered
    // state, which is what gives the one-cycle latency after entering RUN.
    always_comb begin
        count_next = count;
        pulse_next = 1'b0;
        step       = 1'b0;
        wrap       = 1'b0;
        if (load_en) begin
            count_next = load[BIT_WIDTH-1:0];
        end else if (state == RUN) begin
            step = 1'b1;
            if (upordown) begin
                wrap       = (count == C_ALL_ONES);
                count_next = count + C_ONE;
            end else begin
                wrap       = (count == C_ZERO);
                count_next = count - C_ONE;
            end
            pulse_next = step & wrap;
        end
    end

    // Output registers; both outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= C_ZERO;
            pulse <= 1'b0;
        end else begin
            count <= count_next;
            pulse <= pulse_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_counter
//  Description : Directed self-checking bench for load_counter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_counter;

    localparam int BIT_WIDTH = 16;

    logic                 clk;
    logic                 reset;
    logic [31:0]          load;
    logic                 load_en;
    logic                 upordown;
    logic                 start;
    logic                 continue_1;
    logic [BIT_WIDTH-1:0] count;
    logic                 pulse;

    int checks;
    int failures;

    load_counter #(.BIT_WIDTH(BIT_WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_en    (load_en),
        .upordown   (upordown),
        .start      (start),
        .continue_1 (continue_1),
        .count      (count),
        .pulse      (pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            load       = $urandom;
            load_en    = 1'($urandom_range(0, 1));
            upordown   = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            continue_1 = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (count !== 16'd0 || pulse !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: count=%h pulse=%b expected count=0000 pulse=0", i, count, pulse);
            end
        end
        load_en = 1'b0; start = 1'b0; continue_1 = 1'b0; upordown = 1'b1; load = 32'd0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 16'd0) begin
                failures++;
                $display("FAIL reset_release cycle %0d: count=%h expected 0000", i, count);
            end
        end
    endtask

    task automatic test_load_stopped();
        load = 32'd100; load_en = 1'b1; upordown = 1'b1; start = 1'b0;
        tick();
        checks++;
        if (count !== 16'd100 || pulse !== 1'b0) begin
            failures++;
            $display("FAIL load_stopped: count=%0d pulse=%b expected count=100 pulse=0", count, pulse);
        end
        load_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 16'd100) begin
                failures++;
                $display("FAIL hold_stopped cycle %0d: count=%0d expected 100", i, count);
            end
        end
    endtask

    task automatic test_run_pause();
        logic [15:0] exp;
        start = 1'b1; continue_1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = 16'(100 + i);
            checks++;
            if (count !== exp) begin
                failures++;
                $display("FAIL run_up cycle %0d: count=%0d expected %0d", i, count, exp);
            end
        end
        continue_1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count !== 16'd110) begin
                failures++;
                $display("FAIL pause_freeze cycle %0d: count=%0d expected 110", i, count);
            end
        end
        continue_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = 16'(110 + i);
            checks++;
            if (count !== exp) begin
                failures++;
                $display("FAIL resume cycle %0d: count=%0d expected %0d", i, count, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_c [8];
        logic        exp_p [8];
        exp_c = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE};
        exp_p = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        load = 32'h0000_FFFE; load_en = 1'b1; upordown = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (count !== exp_c[i] || pulse !== exp_p[i]) begin
                failures++;
                $display("FAIL wrap step %0d: count=%h pulse=%b expected count=%h pulse=%b",
                         i, count, pulse, exp_c[i], exp_p[i]);
            end
            load_en = 1'b0;
            if (i == 3) begin
                load = 32'h0000_0001; load_en = 1'b1; upordown = 1'b0;
            end
        end
    endtask

    task automatic test_load_during_run();
        upordown = 1'b1; load = 32'h0000_FFFF; load_en = 1'b1;
        tick();
        checks++;
        if (count !== 16'hFFFF || pulse !== 1'b0) begin
            failures++;
            $display("FAIL run_load_ffff: count=%h pulse=%b expected count=ffff pulse=0", count, pulse);
        end
        // A load at terminal count overrides the wrapping step and gives no pulse.
        load = 32'h0001_0005;
        tick();
        checks++;
        if (count !== 16'h0005 || pulse !== 1'b0) begin
            failures++;
            $display("FAIL run_load_trunc: count=%h pulse=%b expected count=0005 pulse=0", count, pulse);
        end
        load_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count !== 16'(6 + i)) begin
                failures++;
                $display("FAIL run_after_load cycle %0d: count=%h expected %h", i, count, 16'(6 + i));
            end
        end
    endtask

    task automatic test_async_reset();
        tick();
        checks++;
        if (count !== 16'h0008) begin
            failures++;
            $display("FAIL pre_reset: count=%h expected 0008", count);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (count !== 16'd0 || pulse !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: count=%h pulse=%b expected count=0000 pulse=0", count, pulse);
        end
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count !== 16'd0) begin
                failures++;
                $display("FAIL post_reset_idle cycle %0d: count=%h expected 0000", i, count);
            end
        end
        start = 1'b1; continue_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 16'(i)) begin
                failures++;
                $display("FAIL post_reset_run cycle %0d: count=%h expected %h", i, count, 16'(i));
            end
        end
    endtask

    task automatic test_stop_and_pause_from_idle();
        logic [15:0] exp_c [6];
        exp_c = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd4};
        // Stop from RUN: last step on the stopping edge, then hold (no clear).
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (count !== exp_c[i]) begin
                failures++;
                $display("FAIL stop_pause step %0d: count=%h expected %h", i, count, exp_c[i]);
            end
            if (i == 1) begin
                start = 1'b1; continue_1 = 1'b0;
            end
            if (i == 3) begin
                continue_1 = 1'b1;
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; load = 32'd0; load_en = 1'b0; upordown = 1'b0;
        start = 1'b0; continue_1 = 1'b0;
        #1;
        test_reset();
        test_load_stopped();
        test_run_pause();
        test_wrap();
        test_load_during_run();
        test_async_reset();
        test_stop_and_pause_from_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
